fnd_scan_counter: RTL and testbench

Parametrised digit-scan sequencer for multiplexed FND (7-segment) displays. It generalises the fixed 2-bit free-running digit counter to N digits and adds:
- an internal slot prescaler on the system clock;
- a run enable and a synchronous clear;
- per-digit enable masking, so disabled digits are skipped;
- one-hot active-low common outputs, plus tick and frame strobes.

It sits between the system clock domain and the FND segment mux/decoder. The decoder uses o_digit_idx to select the nibble to display.

---
 rtl/fnd_scan_counter.sv | 133 +++++++++++++
 tb/tb_fnd_scan_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_counter.sv
// Multiplexed FND digit-scan sequencer: slot prescaler, masked digit rotation, active-low commons.
// Optional anti-ghosting dead time at the start of each slot is enabled by defining FND_BLANK_GUARD_EN.
module fnd_scan_counter #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_en,
    input  logic                          i_clr,
    input  logic [NUM_DIGITS-1:0]         i_digit_mask,
    output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
    output logic [NUM_DIGITS-1:0]         o_com,
    output logic                          o_tick,
    output logic                          o_frame
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_DIV - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || CLK_DIV < 2 || BLANK_CYCLES < 0) begin : g_bad_params
        $error("fnd_scan_counter: illegal parameter combination");
    end

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick_q, tick_d;
    logic                  frame_q, frame_d;
    logic [IDX_W:0]        next_s;
    logic [NUM_DIGITS-1:0] com_raw_s;
    logic [NUM_DIGITS-1:0] com_s;

    // Rotating search from cur+1 that ends on cur itself; MSB of the result flags that a digit was found.
    function automatic logic [IDX_W:0] find_next(input logic [IDX_W-1:0] cur,
                                                 input logic [NUM_DIGITS-1:0] mask);
        logic             found;
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        sel   = cur;
        for (int off = 1; off <= NUM_DIGITS; off++) begin
            cand = IDX_W'((int'(cur) + off) % NUM_DIGITS);
            if (!found && mask[cand]) begin
                found = 1'b1;
                sel   = cand;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Next-state logic: clear beats enable, enable gates the prescaler and the terminal-count advance.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        next_s  = find_next(idx_q, i_digit_mask);
        if (i_clr) begin
            pre_d = {PRE_W{1'b0}};
            idx_d = {IDX_W{1'b0}};
        end else if (i_en) begin
            if (pre_q == PRE_TC) begin
                pre_d  = {PRE_W{1'b0}};
                tick_d = 1'b1;
                if (next_s[IDX_W]) begin
                    idx_d   = next_s[IDX_W-1:0];
                    frame_d = (next_s[IDX_W-1:0] <= idx_q);
                end else begin
                    idx_d   = idx_q;
                    frame_d = 1'b0;
                end
            end else begin
                pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // State and strobe registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_q   <= {PRE_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    // Common drive follows the live mask so a digit masked mid-slot blanks at once.
    always_comb begin
        com_raw_s = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx_q && i_digit_mask[k]) begin
                com_raw_s[k] = 1'b0;
            end else begin
                com_raw_s[k] = 1'b1;
            end
        end
    end

`ifdef FND_BLANK_GUARD_EN
    if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
        $error("fnd_scan_counter: BLANK_CYCLES must be below CLK_DIV");
    end

    // Dead time: all commons off during the first BLANK_CYCLES clocks of every slot.
    always_comb begin
        if (pre_q < PRE_W'(BLANK_CYCLES)) begin
            com_s = {NUM_DIGITS{1'b1}};
        end else begin
            com_s = com_raw_s;
        end
    end
`else
    assign com_s = com_raw_s;
`endif

    assign o_digit_idx = idx_q;
    assign o_com       = com_s;
    assign o_tick      = tick_q;
    assign o_frame     = frame_q;

endmodule

// File: tb/tb_fnd_scan_counter.sv
// Scoreboard bench for fnd_scan_counter: a slot/enabled-list reference model queues expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_fnd_scan_counter;

    localparam int ND = 4;
`ifdef FND_BLANK_GUARD_EN
    localparam int CD = 8;
    localparam int BC = 2;
`else
    localparam int CD = 4;
    localparam int BC = 4;
`endif

    typedef struct {
        logic [1:0] idx;
        logic       tick;
        logic       frame;
        logic [3:0] com;
    } exp_t;

    logic       clk;
    logic       i_reset_n;
    logic       i_en;
    logic       i_clr;
    logic [3:0] i_digit_mask;
    logic [1:0] o_digit_idx;
    logic [3:0] o_com;
    logic       o_tick;
    logic       o_frame;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: position within the current slot and the displayed digit.
    int   m_cnt = 0;
    int   m_idx = 0;
    logic m_tick = 1'b0;
    logic m_frame = 1'b0;

    fnd_scan_counter #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_en        (i_en),
        .i_clr       (i_clr),
        .i_digit_mask(i_digit_mask),
        .o_digit_idx (o_digit_idx),
        .o_com       (o_com),
        .o_tick      (o_tick),
        .o_frame     (o_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next lit digit: smallest enabled index above cur, else wrap to the smallest enabled index.
    function automatic int next_enabled(input int cur, input logic [3:0] mask);
        int lst[$];
        for (int k = 0; k < ND; k++) if (mask[k]) lst.push_back(k);
        if (lst.size() == 0) return -1;
        foreach (lst[i]) if (lst[i] > cur) return lst[i];
        return lst[0];
    endfunction

    function automatic logic [3:0] model_com(input logic [3:0] mask);
        logic [3:0] c;
        c = 4'b1111;
        if (mask[m_idx]) c[m_idx] = 1'b0;
`ifdef FND_BLANK_GUARD_EN
        if (m_cnt < BC) c = 4'b1111;
`endif
        return c;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_tick = 1'b0; m_frame = 1'b0;
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, queue it, wait one clock.
    task automatic cycle(input logic en, input logic clr, input logic [3:0] mask);
        exp_t e;
        int   nx;
        i_en = en; i_clr = clr; i_digit_mask = mask;
        m_tick = 1'b0; m_frame = 1'b0;
        if (clr) begin
            m_cnt = 0; m_idx = 0;
        end else if (en) begin
            if (m_cnt == CD - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                nx = next_enabled(m_idx, mask);
                if (nx >= 0) begin
                    m_frame = (nx <= m_idx);
                    m_idx   = nx;
                end
            end else begin
                m_cnt++;
            end
        end
        e.idx = 2'(m_idx); e.tick = m_tick; e.frame = m_frame; e.com = model_com(mask);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("idx",   32'(o_digit_idx), 32'(e.idx));
                check("tick",  32'(o_tick),      32'(e.tick));
                check("frame", 32'(o_frame),     32'(e.frame));
                check("com",   32'(o_com),       32'(e.com));
            end
        end
    end

    initial begin
        int  guard;
        logic [3:0] rmask;
        logic rclr, ren;
        i_reset_n = 1'b0; i_en = 1'b0; i_clr = 1'b0; i_digit_mask = 4'b0000;
        #1;
        check("rst_idx",   32'(o_digit_idx), 32'd0);
        check("rst_tick",  32'(o_tick),      32'd0);
        check("rst_frame", 32'(o_frame),     32'd0);
        check("rst_com",   32'(o_com),       32'hF);
        @(negedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
        model_reset();

        // Full scan, then masked patterns including a single enabled digit.
        repeat (40) cycle(1'b1, 1'b0, 4'b1111);
        repeat (20) cycle(1'b1, 1'b0, 4'b0101);
        repeat (12) cycle(1'b1, 1'b0, 4'b0100);

        // Freeze at prescaler 2, digit 1.
        guard = 0;
        while (!(m_idx == 1 && m_cnt == 2) && guard < 64) begin
            cycle(1'b1, 1'b0, 4'b1111);
            guard++;
        end
        check("freeze_reach", 32'(guard < 64), 32'd1);
        repeat (10) cycle(1'b0, 1'b0, 4'b1111);
        repeat (6)  cycle(1'b1, 1'b0, 4'b1111);

        // Empty mask, then clear landing on a terminal count.
        repeat (12) cycle(1'b1, 1'b0, 4'b0000);
        guard = 0;
        while (!(m_cnt == CD - 1 && m_idx != 0) && guard < 64) begin
            cycle(1'b1, 1'b0, 4'b1111);
            guard++;
        end
        check("clr_reach", 32'(guard < 64), 32'd1);
        cycle(1'b1, 1'b1, 4'b1111);
        repeat (8) cycle(1'b1, 1'b0, 4'b1111);

        // Async reset between edges right after the step onto digit 3 while tick is still high.
        guard = 0;
        while (!(m_tick && m_idx == 3) && guard < 64) begin
            cycle(1'b1, 1'b0, 4'b1111);
            guard++;
        end
        check("arst_reach", 32'(guard < 64), 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_idx",   32'(o_digit_idx), 32'd0);
        check("arst_tick",  32'(o_tick),      32'd0);
        check("arst_frame", 32'(o_frame),     32'd0);
        @(negedge clk);
        i_reset_n = 1'b1;
        model_reset();
        repeat (12) cycle(1'b1, 1'b0, 4'b1111);

        // Randomized enable, clear and mask traffic.
        rmask = 4'b1111;
        repeat (800) begin
            if ($urandom_range(0, 9) == 0) rmask = 4'($urandom_range(0, 15));
            ren  = ($urandom_range(0, 9) != 0);
            rclr = ($urandom_range(0, 39) == 0);
            cycle(ren, rclr, rmask);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 5) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
